// File: rtl/datapath_gen_pkg.sv
// Shared types, select encodings and helpers for the generalised LC-3 datapath.
package datapath_gen_pkg;

    localparam int SEXT_MAX_W = 64;

    // Bit positions inside the gate and ld control vectors.
    localparam int G_MARMUX = 0;
    localparam int G_PC     = 1;
    localparam int G_ALU    = 2;
    localparam int G_MDR    = 3;

    localparam int LD_REG_B = 0;
    localparam int LD_BEN_B = 1;
    localparam int LD_CC_B  = 2;
    localparam int LD_IR_B  = 3;
    localparam int LD_MAR_B = 4;
    localparam int LD_MDR_B = 5;
    localparam int LD_PC_B  = 6;
    localparam int LD_LED_B = 7;

    typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_NOT, ALU_PASS} aluk_e;
    typedef enum logic [1:0] {PC_INC, PC_BUS, PC_ADDR, PC_HOLD} pcmux_e;
    typedef enum logic [1:0] {A2_ZERO, A2_OFF6, A2_OFF9, A2_OFF11} addr2mux_e;
    typedef enum logic [1:0] {DR_IR11, DR_R7, DR_R6, DR_RSV} drmux_e;
    typedef enum logic [1:0] {SR1_IR11, SR1_IR8, SR1_R6, SR1_RSV} sr1mux_e;
    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} mem_state_e;

    // Sign-extends the low 'bits' bits of v; callers truncate to their width.
    function automatic logic [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] v,
                                                   input logic [6:0] bits);
        logic [6:0] sh;
        sh = 7'(SEXT_MAX_W) - bits;
        return $signed(v << sh) >>> sh;
    endfunction

endpackage

// File: rtl/datapath_gen_if.sv
// Memory request/acknowledge bus between the datapath and the SRAM wrapper.
interface datapath_gen_if #(parameter int WIDTH = 16);
    logic             mem_req;
    logic             mem_wr;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;

    modport master (output mem_req, mem_wr, mem_addr, mem_wdata,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_wr, mem_addr, mem_wdata,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/datapath_gen_mem.sv
// Memory handshake FSM: holds req until ack, aborts with a sticky error after
// MEM_TIMEOUT unanswered request cycles.
module mem_handshake
    import datapath_gen_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic we_i,
    input  logic ack_i,
    output logic req_o,
    output logic wr_o,
    output logic busy_o,
    output logic done_o,
    output logic err_o,
    output logic rd_capture_o
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    mem_state_e       state_q;
    logic             wr_q;
    logic             done_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= REQ;
                        wr_q    <= we_i;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                REQ: begin
                    // An ack on the last allowed cycle still counts as success.
                    if (ack_i) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign req_o        = (state_q == REQ);
    assign busy_o       = (state_q == REQ);
    assign wr_o         = wr_q & (state_q == REQ);
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign rd_capture_o = (state_q == REQ) & ack_i & ~wr_q;

endmodule

// File: rtl/datapath_gen.sv
// Generalised LC-3 datapath: gated shared bus, 8-entry register file, ALU,
// PC/IR/MAR/MDR, NZP/BEN, LED register and a handshaked memory port.
module datapath_gen
    import datapath_gen_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int MEM_TIMEOUT = 15,
    parameter int LED_W       = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [3:0]        gate,
    input  logic [7:0]        ld,
    input  logic [1:0]        PCMUX,
    input  logic [1:0]        DRMUX,
    input  logic [1:0]        SR1MUX,
    input  logic [1:0]        ADDR2MUX,
    input  logic [1:0]        ALUK,
    input  logic              ADDR1MUX,
    input  logic              SR2MUX,
    input  logic              mem_start,
    input  logic              mem_we,
    datapath_gen_if.master    mem,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_err,
    output logic              bus_conflict,
    output logic [WIDTH-1:0]  IR_out,
    output logic [WIDTH-1:0]  PC_out,
    output logic [WIDTH-1:0]  MAR_out,
    output logic [WIDTH-1:0]  MDR_out,
    output logic              BEN,
    output logic [LED_W-1:0]  LED
);

    logic [WIDTH-1:0] pc_q, ir_q, mar_q, mdr_q;
    logic [WIDTH-1:0] regfile_q [8];
    logic [2:0]       nzp_q;
    logic             ben_q;
    logic [LED_W-1:0] led_q;

    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] bus, alu, alu_b, addr1, addr2, addr_sum, sr1_val, sr2_val;
    logic [WIDTH-1:0] imm5, off6, off9, off11;
    logic [2:0]       dr_sel, sr1_sel;
    logic             rd_capture;

    assign imm5  = WIDTH'(sext(SEXT_MAX_W'(ir_q[4:0]),  7'd5));
    assign off6  = WIDTH'(sext(SEXT_MAX_W'(ir_q[5:0]),  7'd6));
    assign off9  = WIDTH'(sext(SEXT_MAX_W'(ir_q[8:0]),  7'd9));
    assign off11 = WIDTH'(sext(SEXT_MAX_W'(ir_q[10:0]), 7'd11));

    always_comb begin
        dr_sel = ir_q[11:9];
        case (drmux_e'(DRMUX))
            DR_R7:   dr_sel = 3'd7;
            DR_R6:   dr_sel = 3'd6;
            default: dr_sel = ir_q[11:9];
        endcase
        sr1_sel = ir_q[11:9];
        case (sr1mux_e'(SR1MUX))
            SR1_IR8: sr1_sel = ir_q[8:6];
            SR1_R6:  sr1_sel = 3'd6;
            default: sr1_sel = ir_q[11:9];
        endcase
    end

    assign sr1_val = regfile_q[sr1_sel];
    assign sr2_val = regfile_q[ir_q[2:0]];
    assign alu_b   = SR2MUX ? imm5 : sr2_val;
    assign addr1   = ADDR1MUX ? sr1_val : pc_q;

    always_comb begin
        alu = sr1_val;
        case (aluk_e'(ALUK))
            ALU_ADD:  alu = sr1_val + alu_b;
            ALU_AND:  alu = sr1_val & alu_b;
            ALU_NOT:  alu = ~sr1_val;
            ALU_PASS: alu = sr1_val;
        endcase
        addr2 = '0;
        case (addr2mux_e'(ADDR2MUX))
            A2_ZERO:  addr2 = '0;
            A2_OFF6:  addr2 = off6;
            A2_OFF9:  addr2 = off9;
            A2_OFF11: addr2 = off11;
        endcase
    end

    assign addr_sum     = addr1 + addr2;
    assign bus_conflict = ($countones(gate) > 1);

    // Zero or several drivers both leave the bus at 0.
    always_comb begin
        bus = '0;
        if ($countones(gate) == 1) begin
            if (gate[G_MDR])      bus = mdr_q;
            else if (gate[G_ALU]) bus = alu;
            else if (gate[G_PC])  bus = pc_q;
            else                  bus = addr_sum;
        end
    end

    always_comb begin
        pc_d = pc_q;
        case (pcmux_e'(PCMUX))
            PC_INC:  pc_d = pc_q + 1'b1;
            PC_BUS:  pc_d = bus;
            PC_ADDR: pc_d = addr_sum;
            PC_HOLD: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            nzp_q <= 3'b010;
            ben_q <= 1'b0;
            led_q <= '0;
            for (int i = 0; i < 8; i++) regfile_q[i] <= '0;
        end else begin
            if (ld[LD_REG_B]) regfile_q[dr_sel] <= bus;
            if (ld[LD_PC_B])  pc_q  <= pc_d;
            if (ld[LD_IR_B])  ir_q  <= bus;
            if (ld[LD_MAR_B]) mar_q <= bus;
            // A read completing this cycle takes priority over a bus load.
            if (rd_capture)          mdr_q <= mem.mem_rdata;
            else if (ld[LD_MDR_B])   mdr_q <= bus;
            if (ld[LD_CC_B])
                nzp_q <= {bus[WIDTH-1], bus == '0, ~bus[WIDTH-1] & (bus != '0)};
            if (ld[LD_BEN_B]) ben_q <= |(ir_q[11:9] & nzp_q);
            if (ld[LD_LED_B]) led_q <= ir_q[LED_W-1:0];
        end
    end

    mem_handshake #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem (
        .clk          (Clk),
        .rst_n        (Reset),
        .start_i      (mem_start),
        .we_i         (mem_we),
        .ack_i        (mem.mem_ack),
        .req_o        (mem.mem_req),
        .wr_o         (mem.mem_wr),
        .busy_o       (mem_busy),
        .done_o       (mem_done),
        .err_o        (mem_err),
        .rd_capture_o (rd_capture)
    );

    assign mem.mem_addr  = mar_q;
    assign mem.mem_wdata = mdr_q;
    assign IR_out        = ir_q;
    assign PC_out        = pc_q;
    assign MAR_out       = mar_q;
    assign MDR_out       = mdr_q;
    assign BEN           = ben_q;
    assign LED           = led_q;

endmodule
